// File: rtl/dsp48a1_mac_sequencer.sv
// Sequencer that drives one DSP48A1 slice as a multiply-accumulate engine:
// takes a job, streams operand pairs with matching Opmode/CE/RstP, then hands back P.
module dsp48a1_mac_sequencer #(
    parameter int LEN_W = 10
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             sub,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_a,
    input  logic [17:0]      in_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data,
    output logic [17:0]      dsp_A,
    output logic [17:0]      dsp_B,
    output logic             dsp_CEA,
    output logic             dsp_CEB,
    output logic [7:0]       dsp_Opmode,
    output logic             dsp_CEP,
    output logic             dsp_RstP,
    output logic             dsp_RstCarryin,
    input  logic [47:0]      dsp_P,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic             first;
    logic             sub_q;
    logic             cep_q;
    logic             accept;
    logic             start_accept;

    // Both handshakes transfer on a cycle where valid and ready are high together;
    // valid may not depend on ready, and the payload is only meaningful while valid is high.
    assign in_ready     = (state == RUN);
    assign busy         = (state != IDLE);
    assign res_valid    = (state == DONE);
    assign accept       = in_valid & in_ready;
    assign start_accept = start & (state == IDLE);
    assign state_dbg    = state;

    assign res_data       = dsp_P;
    assign dsp_A          = in_a;
    assign dsp_B          = in_b;
    assign dsp_CEA        = accept;
    assign dsp_CEB        = accept;
    assign dsp_CEP        = cep_q;
    assign dsp_RstP       = Rst | start_accept;
    assign dsp_RstCarryin = Rst | start_accept;

    // X = A1*B1 always; Z = 0 for the first product, P afterwards; bit 7 selects subtract.
    assign dsp_Opmode = accept ? {sub_q, 3'b000, (first ? 2'b00 : 2'b10), 2'b01} : 8'h00;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            remaining <= '0;
            first     <= 1'b0;
            sub_q     <= 1'b0;
            cep_q     <= 1'b0;
        end else begin
            cep_q <= accept;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= len;
                        sub_q     <= sub;
                        first     <= 1'b1;
                        state     <= (len != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (accept) begin
                        remaining <= remaining - LEN_W'(1);
                        first     <= 1'b0;
                        if (remaining == LEN_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                // One extra cycle lets the last product land in P.
                DRAIN: state <= DONE;
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
